// File: rtl/if_stage.sv
// Instruction-fetch stage: direct-mapped one-word-per-line I-cache lookup,
// single outstanding miss to memory, and issue of {pc, inst} to decode.
module if_stage #(
  parameter int unsigned ICACHE_ENTRIES = 128
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] pc_in,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int unsigned IDX  = $clog2(ICACHE_ENTRIES);
  localparam int unsigned TAGW = 30 - IDX;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                    r_state;
  logic [ICACHE_ENTRIES-1:0] r_valid;
  logic [TAGW-1:0]           r_tag  [ICACHE_ENTRIES];
  logic [31:0]               r_data [ICACHE_ENTRIES];
  logic                      r_discard;
  logic                      r_mem_req;
  logic [31:0]               r_mem_addr;
  logic                      r_id_valid;
  logic [31:0]               r_id_pc;
  logic [31:0]               r_id_inst;

  logic [IDX-1:0]  w_idx;
  logic [TAGW-1:0] w_tag;
  logic            w_hit;
  logic [IDX-1:0]  w_fill_idx;
  logic [TAGW-1:0] w_fill_tag;
  logic            w_fill;
  logic            w_fill_issue;
  logic            w_unused_bits;

  assign w_idx         = pc_in[IDX+1:2];
  assign w_tag         = pc_in[31:IDX+2];
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill_idx    = r_mem_addr[IDX+1:2];
  assign w_fill_tag    = r_mem_addr[31:IDX+2];
  assign w_fill        = rdy_in && !rst_in && (r_state == S_WAIT) && mem_done;
  assign w_fill_issue  = !r_discard && !flush_in && !stall_in;
  assign w_unused_bits = ^{pc_in[1:0], r_mem_addr[1:0]};

  // PC must hold while a miss is unresolved or a wrong-path fill is retiring
  assign stall_out = stall_in
                   | ((r_state == S_IDLE) & !w_hit & !flush_in)
                   | ((r_state == S_WAIT) & !(mem_done & !r_discard & !flush_in));

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign id_valid = r_id_valid;
  assign id_pc    = r_id_pc;
  assign id_inst  = r_id_inst;

  // Tag/data storage carries no reset; only the valid bits qualify a line
  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_discard  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
      r_id_valid <= 1'b0;
      r_id_pc    <= 32'h0;
      r_id_inst  <= 32'h0;
    end else if (rdy_in) begin
      case (r_state)
        S_IDLE: begin
          if (flush_in) begin
            r_id_valid <= 1'b0;
          end else if (stall_in) begin
            r_id_valid <= r_id_valid;
          end else if (w_hit) begin
            r_id_valid <= 1'b1;
            r_id_pc    <= pc_in;
            r_id_inst  <= r_data[w_idx];
          end else begin
            r_id_valid <= 1'b0;
            r_mem_req  <= 1'b1;
            r_mem_addr <= pc_in;
            r_discard  <= 1'b0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            // The fill always lands; only the issue depends on path/backpressure
            r_valid[w_fill_idx] <= 1'b1;
            r_mem_req           <= 1'b0;
            r_state             <= S_IDLE;
            if (w_fill_issue) begin
              r_id_valid <= 1'b1;
              r_id_pc    <= r_mem_addr;
              r_id_inst  <= mem_data;
            end else begin
              r_id_valid <= 1'b0;
            end
          end else if (flush_in) begin
            r_discard  <= 1'b1;
            r_id_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage sitting directly downstream of the PC register and upstream of the IF/ID latch. It takes the current fetch PC and looks it up in a direct-mapped instruction cache. On a miss it requests the 32-bit word from the memory controller and fills the cache. It then hands {pc, instruction} to decode and generates the stall that freezes the PC register on a miss.

## Interface
- ICACHE_ENTRIES, 128, number of one-word cache lines; power of two, ≥2; IDX = log2(ICACHE_ENTRIES)
- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  reset; synchronous, active-high
- rdy_in  input  1  global ready; low freezes every register (cache, state, outputs)
- pc_in  input  32  fetch PC from PC register; word-aligned
- stall_in  input  1  downstream (decode) cannot accept
- flush_in  input  1  jump taken this cycle; pc_in is wrong-path
- stall_out  output  1  to PC register stall; combinational
- mem_req  output  1  fetch request to memory controller; registered
- mem_addr  output  32  fetch address; registered
- mem_done  input  1  one-cycle pulse: mem_data valid
- mem_data  input  32  fetched word
- id_valid  output  1  id_inst/id_pc valid; registered
- id_pc  output  32  PC of issued instruction; registered
- id_inst  output  32  issued instruction; registered

## Operation
- Cache: index = pc[IDX+1:2], tag = pc[31:IDX+2]; per line a valid bit, tag, and 32-bit data. Only valid bits are reset (to 0). hit = valid[index] & tag match, combinational on pc_in.
- States: IDLE, WAIT.
- IDLE, flush_in=1: id_valid<=0, no request, stay IDLE (flush has priority over everything).
- IDLE, stall_in=1: hold id_* unchanged, no request, stay IDLE.
- IDLE, hit: id_pc<=pc_in, id_inst<=cache data, id_valid<=1.
- IDLE, miss: id_valid<=0, mem_req<=1, mem_addr<=pc_in, discard<=0; go WAIT.
- WAIT: mem_req stays 1 until the mem_done cycle. flush_in in WAIT sets discard<=1 and id_valid<=0. The request is never cancelled.
- WAIT, mem_done: always write line (valid=1, tag/data from mem_addr/mem_data); mem_req<=0; go IDLE.
  - Issue to decode (id_pc<=mem_addr, id_inst<=mem_data, id_valid<=1) only if discard=0, flush_in=0 and stall_in=0.
  - Otherwise id_valid<=0. The retried PC later hits in IDLE.
- stall_out = stall_in | (IDLE & !hit & !flush_in) | (WAIT & !(mem_done & !discard & !flush_in)).
- Upstream contract: while stall_out=1 and flush_in=0, pc_in is held constant. On flush_in, pc_in becomes the target on the next cycle.
- rst_in: state=IDLE, all valid bits=0, mem_req=0, mem_addr=0, discard=0, id_valid=0, id_pc=0, id_inst=0. Applies mid-miss too; a later stray mem_done in IDLE is ignored.
- rdy_in=0: nothing updates; stall_out is still driven from current state and inputs.

## Timing
- Hit: pc_in valid in cycle N → id_* valid after edge N; stall_out=0; one instruction per cycle sustained.
- Miss: stall_out=1 from cycle N (combinational); mem_req=1 from N+1. On mem_done in cycle M, stall_out=0 in M and id_valid=1 after edge M. Miss penalty = M−N cycles.
- The same pc_in re-presented after a fill is a hit.
- mem_done while discard=1: stall_out stays 1 through that cycle. The target PC is looked up in IDLE on M+1.
- flush_in and mem_done in the same cycle: fill cache, no issue, stall_out=1.
- Aliasing: a fill replaces a line with a different tag unconditionally.

## Test plan
- Reset then cold fetch: pc_in=0x0, mem_done after 3 cycles with 0x00000013 → mem_req=1/mem_addr=0x0 for 3 cycles; id_valid=1, id_pc=0, id_inst=0x13 after done; stall_out low in done cycle.
- Warm loop: refetch 0x0,0x4,0x8 after fill → id_valid=1 every cycle, mem_req never asserts, stall_out=0.
- Flush mid-miss: miss on 0x100, flush_in at cycle 2 with pc_in→0x200 → 0x100 line filled but never issued; stall_out=1 until done+1; then miss on 0x200 issued.
- Downstream stall: stall_in=1 when mem_done arrives for 0x40 → id_valid=0, line valid; after stall_in drops, 0x40 issued via hit with no new mem_req.
- Alias eviction (ICACHE_ENTRIES=128): fill 0x000 then 0x200 → 0x000 misses again with mem_req=1.
- rdy_in=0 for 5 cycles during WAIT with mem_done low → all outputs frozen; resumes exactly. Reset asserted in WAIT → mem_req=0, id_valid=0 next cycle, previous lines miss.
